counter_sequencer: RTL and testbench

Command-driven controller for the team's up/down counter datapath. It accepts a counting job (start value, target value, direction) through a valid/ready handshake, loads the counter, and steps it one unit per cycle until the target is reached. It then signals completion and returns to idle for the next job. It sits between a host FSM or test harness and the counter, so no requester drives the counter directly.

---
 rtl/counter_seq_pkg.sv | 12 +
 rtl/counter_updown_load.sv | 43 ++++
 rtl/counter_sequencer.sv | 113 +++++++++++
 tb/tb_counter_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer slice.
package counter_seq_pkg;

  localparam int unsigned NBITS_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/counter_updown_load.sv
// Loadable up/down counter datapath; wrap flags a step that crosses max<->0.
module counter_updown_load
  import counter_seq_pkg::*;
#(
  parameter int unsigned NBITS_COUNT = NBITS_COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] load_value,
  input  logic                   enable,
  input  logic                   dir,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   wrap
);

  localparam logic [NBITS_COUNT-1:0] ONE = NBITS_COUNT'(1);

  logic [NBITS_COUNT-1:0] count_q, count_d;

  // Next count: load wins over a step; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = dir ? (count_q + ONE) : (count_q - ONE);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = enable && !load && (dir ? (&count_q) : (~|count_q));

endmodule

// File: rtl/counter_sequencer.sv
// Job sequencer: accepts start/target/dir, steps the counter to target, pulses done/aborted.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned NBITS_COUNT = NBITS_COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NBITS_COUNT-1:0] cmd_start,
  input  logic [NBITS_COUNT-1:0] cmd_target,
  input  logic                   cmd_dir,
  input  logic                   hold,
  input  logic                   abort,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   wrapped
);

  seq_state_t             state_q, state_d;
  logic [NBITS_COUNT-1:0] target_q, target_d;
  logic                   dir_q, dir_d;
  logic                   wrapped_q, wrapped_d;
  logic                   aborted_q, aborted_d;

  logic                   ctr_load;
  logic                   ctr_enable;
  logic                   ctr_wrap;
  logic [NBITS_COUNT-1:0] ctr_count;

  counter_updown_load #(
    .NBITS_COUNT (NBITS_COUNT)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .load_value (cmd_start),
    .enable     (ctr_enable),
    .dir        (dir_q),
    .count      (ctr_count),
    .wrap       (ctr_wrap)
  );

  // Next-state and datapath control; in RUN abort beats completion beats hold beats step.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    dir_d      = dir_q;
    wrapped_d  = wrapped_q;
    aborted_d  = 1'b0;
    ctr_load   = 1'b0;
    ctr_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ctr_load  = 1'b1;
          target_d  = cmd_target;
          dir_d     = cmd_dir;
          wrapped_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (ctr_count == target_q) begin
          state_d = DONE;
        end else if (!hold) begin
          ctr_enable = 1'b1;
          if (ctr_wrap) begin
            wrapped_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and job registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      dir_q     <= 1'b0;
      wrapped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      wrapped_q <= wrapped_d;
      aborted_q <= aborted_d;
    end
  end

  // DONE lasts exactly one cycle, so done decodes straight from state.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign wrapped   = wrapped_q;
  assign count     = ctr_count;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: job-level reference model plus directed literal checks.
module tb_counter_sequencer;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [N-1:0] cmd_start = '0;
  logic [N-1:0] cmd_target = '0;
  logic         cmd_dir = 1'b0;
  logic         hold = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] count;
  logic         busy, done, aborted, wrapped;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  counter_sequencer #(.NBITS_COUNT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_dir    (cmd_dir),
    .hold       (hold),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Job-level reference model: a job is a number of remaining steps, not a state machine.
  int m_count, m_left, m_dir;
  bit m_job, m_donep, m_abp, m_wr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0; m_left = 0; m_dir = 0;
      m_job = 0; m_donep = 0; m_abp = 0; m_wr = 0;
    end else begin
      bit was_done;
      was_done = m_donep;
      m_donep  = 0;
      m_abp    = 0;
      if (m_job) begin
        if (abort) begin
          m_job = 0; m_abp = 1;
        end else if (m_left == 0) begin
          m_job = 0; m_donep = 1;
        end else if (!hold) begin
          m_count = (m_count + (m_dir ? 1 : -1)) & MASK;
          m_left--;
          if ((m_dir && m_count == 0) || (!m_dir && m_count == MASK)) m_wr = 1;
        end
      end else if (!was_done && cmd_valid) begin
        m_job   = 1;
        m_dir   = cmd_dir;
        m_count = cmd_start;
        m_left  = cmd_dir ? ((cmd_target - cmd_start) & MASK) : ((cmd_start - cmd_target) & MASK);
        m_wr    = 0;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("m_count",   count,     m_count);
      chk("m_ready",   cmd_ready, !m_job && !m_donep);
      chk("m_busy",    busy,      m_job);
      chk("m_done",    done,      m_donep);
      chk("m_aborted", aborted,   m_abp);
      chk("m_wrapped", wrapped,   m_wr);
    end
  end

  // Present one job for a single accept edge; returns just after the accept-cycle negedge.
  task automatic send(input int s, input int t, input bit d);
    #1;
    cmd_valid  = 1'b1;
    cmd_start  = N'(s);
    cmd_target = N'(t);
    cmd_dir    = d;
    @(negedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_wrapped", wrapped, 0);

    // Up job 3 -> 7
    send(3, 7, 1'b1);
    chk("up_k0", count, 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("up_count", count, 3 + k);
      chk("up_nodone", done, 0);
    end
    @(negedge clk);
    chk("up_done", done, 1);
    chk("up_final", count, 7);
    chk("up_wrapped", wrapped, 0);
    chk("up_notready", cmd_ready, 0);
    @(negedge clk);
    chk("up_ready_back", cmd_ready, 1);
    chk("up_done_once", done, 0);

    // Down wrap 1 -> 14
    send(1, 14, 1'b0);
    chk("dn_k0", count, 1);
    @(negedge clk); chk("dn_k1", count, 0);
    @(negedge clk); chk("dn_k2", count, 15);
    @(negedge clk); chk("dn_k3", count, 14);
    @(negedge clk); chk("dn_done", done, 1); chk("dn_wrapped", wrapped, 1);
    @(negedge clk); chk("dn_idle_wr", wrapped, 1); chk("dn_ready", cmd_ready, 1);

    // start == target = 5
    send(5, 5, 1'b1);
    chk("eq_wr_clear", wrapped, 0);
    chk("eq_k0", count, 5);
    @(negedge clk); chk("eq_done", done, 1); chk("eq_count", count, 5);
    @(negedge clk); chk("eq_ready", cmd_ready, 1);

    // Hold 3 cycles mid-job, 0 -> 4
    send(0, 4, 1'b1);
    @(negedge clk); chk("hd_k1", count, 1);
    @(negedge clk); chk("hd_k2", count, 2);
    #1 hold = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk("hd_frozen", count, 2);
    end
    #1 hold = 1'b0;
    @(negedge clk); chk("hd_k6", count, 3);
    @(negedge clk); chk("hd_k7", count, 4); chk("hd_k7_nodone", done, 0);
    @(negedge clk); chk("hd_done_k8", done, 1);
    @(negedge clk);

    // Abort coinciding with count == target, then immediate new job
    send(6, 8, 1'b1);
    @(negedge clk); chk("ab_k1", count, 7);
    @(negedge clk); chk("ab_k2", count, 8);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("ab_aborted", aborted, 1);
    chk("ab_nodone", done, 0);
    chk("ab_ready", cmd_ready, 1);
    chk("ab_count", count, 8);
    #1 abort = 1'b0;
    send(2, 3, 1'b1);
    chk("ab_reaccept", busy, 1);
    chk("ab_newcount", count, 2);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-RUN, 2 -> 9 after 3 steps
    send(2, 9, 1'b1);
    repeat (3) @(negedge clk);
    chk("rr_before", count, 5);
    #1 reset = 1'b1;
    #1;
    chk("rr_count", count, 0);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_wrapped", wrapped, 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_start  = N'($urandom_range(0, MASK));
      cmd_target = N'($urandom_range(0, MASK));
      cmd_dir    = $urandom_range(0, 1) != 0;
      hold       = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 19) == 0);
    end
    #1;
    cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
